// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   issues instruction-memory requests under a req/ready handshake, buffers
//   returned {instruction, next-PC} pairs in a 2-entry queue and drives the
//   IF/ID Instruction_F / NPC_F / disable_IR / kill inputs.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   stall              hazard unit hold: IF/ID frozen, queue head not consumed
//   redirect_valid/pc  one-cycle taken branch/jump from ID with its target
//   imem_req/addr      instruction-memory request and address
//   imem_ready/rdata   memory completion (may be same cycle) and data word
//   Instruction_F      queue-head instruction, 0 (NOP) when queue empty
//   NPC_F              queue-head PC+PC_STEP, 0 when queue empty
//   fetch_valid        queue non-empty
//   disable_IR_F       stall passthrough to IF/ID disable_IR
//   kill_F             IF/ID kill: queue empty or redirect this cycle
module fetch_stage #(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0]    PC_STEP  = {{(PC_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         Instruction_F,
    output logic [PC_WIDTH-1:0] NPC_F,
    output logic                fetch_valid,
    output logic                disable_IR_F,
    output logic                kill_F
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] drain_addr_q, drain_addr_d;
    logic [1:0]          count_q, count_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;

    logic [31:0]         q_instr_q [2];
    logic [31:0]         q_instr_d [2];
    logic [PC_WIDTH-1:0] q_npc_q   [2];
    logic [PC_WIDTH-1:0] q_npc_d   [2];

    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] pc_plus;

    assign pc_plus = pc_q + PC_STEP;

    // In DRAIN the request to the abandoned address must be held until the
    // memory completes it; in FETCH a request is only made when there is room,
    // so the queue cannot fill underneath an outstanding request.
    assign imem_req  = !reset && ((state_q == S_DRAIN) || (count_q != 2'd2));
    assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

    assign fetch_valid   = (count_q != 2'd0);
    assign Instruction_F = fetch_valid ? q_instr_q[rd_ptr_q] : 32'd0;
    assign NPC_F         = fetch_valid ? q_npc_q[rd_ptr_q] : '0;
    assign disable_IR_F  = stall;
    assign kill_F        = !fetch_valid || redirect_valid;

    assign push = (state_q == S_FETCH) && imem_req && imem_ready && !redirect_valid;
    assign pop  = fetch_valid && !stall && !redirect_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        q_instr_d    = q_instr_q;
        q_npc_d      = q_npc_q;

        if (push) begin
            q_instr_d[wr_ptr_q] = imem_rdata;
            q_npc_d[wr_ptr_q]   = pc_plus;
            wr_ptr_d            = ~wr_ptr_q;
            pc_d                = pc_plus;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A redirect flushes regardless of stall. If a FETCH request is still
        // outstanding its response must be swallowed, so remember its address
        // and keep requesting it in DRAIN.
        if (redirect_valid) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            pc_d     = redirect_pc;
            if ((state_q == S_FETCH) && imem_req && !imem_ready) begin
                drain_addr_d = imem_addr;
                state_d      = S_DRAIN;
            end
        end else if ((state_q == S_DRAIN) && imem_ready) begin
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; entries are only visible while count>0.
    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_npc_q   <= q_npc_d;
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_F;
    logic [31:0] NPC_F;
    logic        fetch_valid;
    logic        disable_IR_F;
    logic        kill_F;

    fetch_stage #(
        .PC_WIDTH (32),
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'd1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .Instruction_F  (Instruction_F),
        .NPC_F          (NPC_F),
        .fetch_valid    (fetch_valid),
        .disable_IR_F   (disable_IR_F),
        .kill_F         (kill_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected program-order stream of the current path (scoreboard).
    logic [31:0] exp_instr [$];
    logic [31:0] exp_npc   [$];

    // Memory model state.
    int          wait_cnt  = 0;
    int          cur_lat   = 0;
    int          lat_min   = 0;
    int          lat_max   = 0;
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    // Reference model state (transaction level).
    int          occ   = 0;
    bit          drop  = 1'b0;
    logic [31:0] fpc   = RESET_PC;
    logic [31:0] drain_a = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill(input logic [31:0] start);
        exp_instr.delete();
        exp_npc.delete();
        for (int i = 0; i < 400; i++) begin
            exp_instr.push_back(mem_word(start + 32'(i)));
            exp_npc.push_back(start + 32'(i) + 32'd1);
        end
    endtask

    task automatic mem_drive();
        if (reset) begin
            imem_ready = 1'b0;
            wait_cnt   = 0;
            pend_valid = 1'b0;
        end else if (imem_req) begin
            if (pend_valid) check("addr_stable", imem_addr, pend_addr);
            if (wait_cnt >= cur_lat) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                cur_lat    = int'($urandom_range(lat_max, lat_min));
                pend_valid = 1'b0;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
            end
        end else begin
            imem_ready = 1'b0;
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit rv, input logic [31:0] rpc);
        reset          = rst;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst) refill(RESET_PC);
        else if (rv) refill(rpc);
        #1;
        mem_drive();
    endtask

    task automatic cycle(input bit rst, input bit st, input bit rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        drive(rst, st, rv, rpc);
    endtask

    task automatic set_lat(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
        cur_lat = hi;
    endtask

    // Monitor: compares DUT outputs with the model, then advances the model
    // by the edge that follows using the inputs currently applied.
    always @(negedge clk) begin
        bit req_e;
        bit push_e;
        bit pop_e;
        if (reset) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_valid", 32'(fetch_valid), 32'd0);
            check("rst_kill", 32'(kill_F), 32'd1);
            check("rst_instr", Instruction_F, 32'd0);
            check("rst_npc", NPC_F, 32'd0);
            occ  = 0;
            drop = 1'b0;
            fpc  = RESET_PC;
        end else begin
            req_e = drop || (occ < 2);
            check("fetch_valid", 32'(fetch_valid), 32'(occ > 0));
            check("kill_F", 32'(kill_F), 32'((occ == 0) || redirect_valid));
            check("disable_IR_F", 32'(disable_IR_F), 32'(stall));
            check("imem_req", 32'(imem_req), 32'(req_e));
            if (req_e) check("imem_addr", imem_addr, drop ? drain_a : fpc);
            if (occ == 0) begin
                check("empty_instr", Instruction_F, 32'd0);
                check("empty_npc", NPC_F, 32'd0);
            end else if (!redirect_valid) begin
                if (exp_instr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL head: got 0x%0h expected none (scoreboard empty)", Instruction_F);
                end else begin
                    check("head_instr", Instruction_F, exp_instr[0]);
                    check("head_npc", NPC_F, exp_npc[0]);
                end
            end
            pop_e  = (occ > 0) && !stall && !redirect_valid;
            push_e = req_e && imem_ready && !drop && !redirect_valid;
            if (pop_e && exp_instr.size() > 0) begin
                void'(exp_instr.pop_front());
                void'(exp_npc.pop_front());
            end
            if (redirect_valid) begin
                if (!drop && req_e && !imem_ready) begin
                    drop    = 1'b1;
                    drain_a = fpc;
                end
                occ = 0;
                fpc = redirect_pc;
            end else begin
                if (drop && imem_ready) drop = 1'b0;
                if (push_e) begin
                    fpc = fpc + 32'd1;
                    occ++;
                end
                if (pop_e) occ--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        refill(RESET_PC);
        set_lat(0, 0);
        repeat (3) cycle(1, 0, 0, 32'd0);

        // Zero-wait stream, then a 4-cycle stall and resume.
        repeat (20) cycle(0, 0, 0, 32'd0);
        repeat (4)  cycle(0, 1, 0, 32'd0);
        repeat (10) cycle(0, 0, 0, 32'd0);

        // Fill the queue under stall, then redirect while still stalled.
        repeat (4) cycle(0, 1, 0, 32'd0);
        cycle(0, 1, 1, 32'h80);
        cycle(0, 1, 0, 32'd0);
        repeat (10) cycle(0, 0, 0, 32'd0);

        // 3-wait memory: redirect to 0x40 while the request to 0x5 is pending.
        set_lat(3, 3);
        cycle(0, 0, 1, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk);
            #1;
            if (imem_req && imem_addr == 32'h5 && wait_cnt < cur_lat) begin
                found = 1'b1;
                drive(0, 0, 1, 32'h40);
            end else begin
                drive(0, 0, 0, 32'd0);
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_0x5: got not-seen expected seen");
        end
        repeat (20) cycle(0, 0, 0, 32'd0);

        // Reset while a request is outstanding.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 0, 0, 32'd0);
            if (pend_valid) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_req: got not-seen expected seen");
        end
        @(posedge clk);
        #1;
        drive(1, 0, 0, 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_valid", 32'(fetch_valid), 32'd0);
        cycle(1, 0, 0, 32'd0);
        set_lat(0, 2);
        repeat (10) cycle(0, 0, 0, 32'd0);

        // Randomized traffic: variable latency, stalls, redirects incl. wrap.
        set_lat(0, 3);
        for (int i = 0; i < 600; i++) begin
            bit          st;
            bit          rv;
            logic [31:0] tgt;
            st = ($urandom % 4) == 0;
            rv = ($urandom % 25) == 0;
            case ($urandom % 3)
                0:       tgt = 32'hFFFF_FFFE;
                1:       tgt = $urandom;
                default: tgt = 32'($urandom_range(255, 0));
            endcase
            cycle(0, st, rv, tgt);
        end
        repeat (5) cycle(0, 0, 0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF-stage block sitting directly upstream of the IF/ID pipeline register. It owns the PC and issues instruction-memory requests under a req/ready handshake. Fetched instruction/NPC pairs are buffered in a 2-entry queue, and the block drives the IF/ID register's Instruction_F, NPC_F, disable_IR and kill inputs. It absorbs decode stalls, multi-cycle instruction memory, and branch/jump redirects from ID.

Parameters:
PC_WIDTH, 32, width of PC, NPC and memory address
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per instruction (word-addressed memory)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
stall  in  1  hazard unit: hold IF/ID, do not pop queue
redirect_valid  in  1  one-cycle pulse from ID: taken branch/jump
redirect_pc  in  PC_WIDTH  target PC, sampled when redirect_valid=1
imem_req  out  1  instruction-memory request
imem_addr  out  PC_WIDTH  request address
imem_ready  in  1  memory returns imem_rdata this cycle (zero-wait allowed)
imem_rdata  in  32  instruction word
Instruction_F  out  32  queue-head instruction; 0 (NOP) when queue empty
NPC_F  out  PC_WIDTH  queue-head PC+PC_STEP; 0 when queue empty
fetch_valid  out  1  queue non-empty
disable_IR_F  out  1  equals stall; drives IF/ID disable_IR
kill_F  out  1  !fetch_valid || redirect_valid; drives IF/ID kill

Behaviour:
- Reset (async): PC=RESET_PC, queue count=0, state=FETCH, drain_addr=0.
- Outputs during reset: imem_req=0. Instruction_F=0, NPC_F=0, fetch_valid=0, kill_F=1, disable_IR_F=stall.
- Queue: 2 entries of {instr[31:0], npc}; read pointer, write pointer and 2-bit count; pointers wrap mod 2.
- All queue outputs are combinational from the head entry, gated to 0 when count=0.
- States: FETCH, DRAIN.
- FETCH: imem_req = (count<2) && !reset; imem_addr = PC.
  - Once raised, req stays high with addr stable until imem_ready, because count cannot rise while a request is pending.
- push (edge): state=FETCH && imem_req && imem_ready && !redirect_valid.
  - Write {imem_rdata, PC+PC_STEP}; PC <= PC+PC_STEP.
- pop (edge): fetch_valid && !stall && !redirect_valid. Same-edge push+pop leaves count unchanged.
- Full queue (count=2): req=0, PC held, no push.
- Empty queue: kill_F=1, so IF/ID loads NOP when not stalled.
- Redirect (redirect_valid=1 at edge; priority over stall and push):
  - count <= 0 (queue flushed); PC <= redirect_pc.
  - If imem_req && !imem_ready that cycle: drain_addr <= imem_addr, state <= DRAIN.
  - If imem_ready that cycle: returned data is discarded and state stays FETCH.
- DRAIN: imem_req=1, imem_addr=drain_addr; no push.
  - On imem_ready: discard imem_rdata, state <= FETCH. The first new-path request is issued the following cycle.
  - A redirect while in DRAIN updates PC only and stays in DRAIN.
- PC arithmetic wraps modulo 2^PC_WIDTH.
- Latency: with zero-wait memory, an instruction requested in cycle N appears on Instruction_F in cycle N+1 and is in IF/ID after edge N+2.
- Steady state is 1 instruction/cycle.
- Reset mid-request: req drops immediately; the in-flight response is ignored by the memory side (memory is reset by the same signal).

Test Plan:
- Zero-wait stream, RESET_PC=0, imem_rdata=0x1000_0000+addr, no stall → Instruction_F sequence 0x10000000, 0x10000001, ... on consecutive cycles; NPC_F=1,2,3...; fetch_valid=1 from cycle 2.
- stall held 4 cycles during the stream → queue fills to 2, imem_req=0, PC frozen, Instruction_F unchanged. After release, instructions resume in order with no gap or duplicate.
- Simultaneous push and pop at count=1 → count stays 1 and the head advances by exactly one instruction.
- 3-wait-state memory, redirect_valid with redirect_pc=0x40 while a request to 0x5 is pending:
  - imem_addr stays 0x5 until ready and that data is dropped;
  - the next request is to 0x40; the first valid Instruction_F is from 0x40 with NPC_F=0x41;
  - kill_F=1 during the redirect cycle.
- Redirect with queue full and stall=1 → count=0, kill_F=1, PC=redirect_pc next cycle; stall does not block the flush.
- Assert reset mid-request (imem_ready=0) → imem_req=0 and fetch_valid=0 immediately. After release, the first imem_addr is RESET_PC.
